// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: DEPTH-entry fetch queue feeding a two-wide issue stage.
// Optional `IFQ_BYPASS_EN forwards pushes straight to fetch_entry when the queue holds 0 or 1 entries.
module instr_fetch_queue #(
    parameter int DEPTH = 8,
    localparam int E_W = 66,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic [1:0]           push_valid,
    input  logic [2*E_W-1:0]     push_entry,
    output logic                 push_ready,
    output logic [2*E_W-1:0]     fetch_entry,
    input  logic [1:0]           fetch_ack,
    output logic [ADDR_W:0]      count,
    output logic                 empty
);
    // Entry layout {valid, vaddr[31:0], instr[31:0], iaddr_ex}; the valid bit is regenerated, not stored.
    logic [E_W-2:0]    r_mem [DEPTH];
    logic [ADDR_W-1:0] r_head, r_tail;
    logic [ADDR_W:0]   r_count;
    logic [E_W-2:0]    w_p0, w_p1, w_fe0, w_fe1;
    logic [1:0]        w_npush, w_ack, w_avail, w_npop;
    logic              w_fv0, w_fv1, w_unused;
    logic [ADDR_W-1:0] w_head1, w_tail1;

    assign w_unused   = push_entry[E_W-1] ^ push_entry[2*E_W-1];
    assign w_head1    = r_head + 1'b1;
    assign w_tail1    = r_tail + 1'b1;
    assign push_ready = r_count <= (ADDR_W+1)'(DEPTH-2);
    assign w_p0       = push_valid[0] ? push_entry[E_W-2:0] : push_entry[2*E_W-2:E_W];
    assign w_p1       = push_entry[2*E_W-2:E_W];
    assign w_npush    = (push_ready && !flush) ? {1'b0, push_valid[0]} + {1'b0, push_valid[1]} : 2'd0;
    assign w_ack      = (fetch_ack == 2'd3) ? 2'd2 : fetch_ack;

    always_comb begin
        w_fe0 = r_mem[r_head];
        w_fe1 = r_mem[w_head1];
        w_fv0 = r_count != '0;
        w_fv1 = r_count >= (ADDR_W+1)'(2);
`ifdef IFQ_BYPASS_EN
        if (!flush && w_npush != 2'd0) begin
            if (r_count == '0) begin
                w_fe0 = w_p0;
                w_fe1 = w_p1;
                w_fv0 = 1'b1;
                w_fv1 = w_npush == 2'd2;
            end else if (r_count == (ADDR_W+1)'(1)) begin
                w_fe1 = w_p0;
                w_fv1 = 1'b1;
            end
        end
`endif
    end

    assign w_avail     = {w_fv1, w_fv0 & ~w_fv1};
    assign w_npop      = flush ? 2'd0 : (w_ack > w_avail ? w_avail : w_ack);
    assign fetch_entry = {w_fv1, w_fe1, w_fv0, w_fe0};
    assign count       = r_count;
    assign empty       = r_count == '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + ADDR_W'(w_npop);
            r_tail  <= r_tail + ADDR_W'(w_npush);
            r_count <= r_count + (ADDR_W+1)'(w_npush) - (ADDR_W+1)'(w_npop);
        end
    end

    // Bypassed-and-acked entries are still written; head skips past them, so they are never seen again.
    always_ff @(posedge clk) begin
        if (rst && w_npush != 2'd0) r_mem[r_tail] <= w_p0;
        if (rst && w_npush == 2'd2) r_mem[w_tail1] <= w_p1;
    end

    a_push_ready: assert property (@(posedge clk) disable iff (!rst || flush) (|push_valid) |-> push_ready);
    a_ack_range:  assert property (@(posedge clk) disable iff (!rst || flush) fetch_ack != 2'd3 && w_ack <= w_avail);
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed checks of fill/drain, wrap, simultaneous push/pop, flush and bypass.
module tb_instr_fetch_queue;
    localparam int DEPTH = 8;
    localparam int E_W = 66;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               flush = 1'b0;
    logic [1:0]         push_valid = '0;
    logic [1:0]         fetch_ack = '0;
    logic [2*E_W-1:0]   push_entry = '0;
    logic               push_ready, empty;
    logic [2*E_W-1:0]   fetch_entry;
    logic [3:0]         count;
    logic [E_W-1:0]     fe0, fe1;
    int                 errors = 0;
    int                 checks = 0;

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .push_valid(push_valid), .push_entry(push_entry),
        .push_ready(push_ready), .fetch_entry(fetch_entry), .fetch_ack(fetch_ack),
        .count(count), .empty(empty)
    );

    assign fe0 = fetch_entry[E_W-1:0];
    assign fe1 = fetch_entry[2*E_W-1:E_W];

    function automatic logic [E_W-1:0] mk(input logic [31:0] va);
        return {1'b1, va, va ^ 32'hC0DE_0000, va[2]};
    endfunction

    task automatic check(input string tag, input logic [E_W-1:0] got, input logic [E_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] pv, input logic [31:0] va0, input logic [31:0] va1, input logic [1:0] ack);
        push_valid = pv;
        push_entry = {mk(va1), mk(va0)};
        fetch_ack  = ack;
        @(posedge clk);
        #1;
        push_valid = '0;
        fetch_ack  = '0;
    endtask

    initial begin
        push_valid = 2'b11;
        push_entry = {mk(32'h50), mk(32'h54)};
        repeat (3) @(posedge clk);
        #1;
        check("rst_count_held", 66'(count), 66'd0);
        check("rst_fe0_valid_held", 66'(fe0[E_W-1]), 66'd0);
        rst = 1'b1;
        push_valid = '0;
        @(posedge clk);
        #1;
        check("rst_count", 66'(count), 66'd0);
        check("rst_empty", 66'(empty), 66'd1);
        check("rst_ready", 66'(push_ready), 66'd1);
        check("rst_fe0_valid", 66'(fe0[E_W-1]), 66'd0);

        cyc(2'b11, 32'h100, 32'h104, 2'd0);
        cyc(2'b11, 32'h108, 32'h10C, 2'd0);
        cyc(2'b11, 32'h110, 32'h114, 2'd0);
        check("fill_count6", 66'(count), 66'd6);
        check("fill_ready6", 66'(push_ready), 66'd1);
        cyc(2'b11, 32'h118, 32'h11C, 2'd0);
        check("fill_count8", 66'(count), 66'd8);
        check("fill_ready8", 66'(push_ready), 66'd0);
        check("fill_fe0", fe0, mk(32'h100));
        check("fill_fe1", fe1, mk(32'h104));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_vaddr%0d", i), 66'(fe0[64:33]), 66'(32'h100 + i * 8));
            cyc(2'b00, 32'h0, 32'h0, 2'd2);
        end
        check("drain_empty", 66'(empty), 66'd1);

        cyc(2'b11, 32'h200, 32'h204, 2'd0);
        cyc(2'b11, 32'h208, 32'h20C, 2'd0);
        cyc(2'b11, 32'h210, 32'h214, 2'd0);
        check("sim_count_before", 66'(count), 66'd6);
        cyc(2'b11, 32'h218, 32'h21C, 2'd2);
        check("sim_count_11", 66'(count), 66'd6);
        check("sim_head_11", fe0, mk(32'h208));
        cyc(2'b10, 32'hDEAD, 32'h220, 2'd1);
        check("sim_count_10", 66'(count), 66'd6);
        check("sim_head_10", fe0, mk(32'h20C));
        cyc(2'b00, 32'h0, 32'h0, 2'd2);
        cyc(2'b00, 32'h0, 32'h0, 2'd2);
        check("wrap_count", 66'(count), 66'd2);
        check("wrap_fe0", fe0, mk(32'h21C));
        check("wrap_fe1", fe1, mk(32'h220));
        cyc(2'b00, 32'h0, 32'h0, 2'd1);
        check("wrap_ack_count", 66'(count), 66'd1);
        check("wrap_ack_fe0", fe0, mk(32'h220));
        check("wrap_ack_fe1_valid", 66'(fe1[E_W-1]), 66'd0);

        cyc(2'b11, 32'h230, 32'h234, 2'd0);
        cyc(2'b11, 32'h238, 32'h23C, 2'd0);
        check("flush_count_before", 66'(count), 66'd5);
        flush = 1'b1;
        cyc(2'b11, 32'h240, 32'h244, 2'd2);
        flush = 1'b0;
        check("flush_count", 66'(count), 66'd0);
        check("flush_empty", 66'(empty), 66'd1);
        check("flush_fe0_valid", 66'(fe0[E_W-1]), 66'd0);
        check("flush_fe1_valid", 66'(fe1[E_W-1]), 66'd0);
        cyc(2'b11, 32'h300, 32'h304, 2'd0);
        check("post_flush_count", 66'(count), 66'd2);
        check("post_flush_fe0", fe0, mk(32'h300));
        check("post_flush_fe1", fe1, mk(32'h304));
        cyc(2'b00, 32'h0, 32'h0, 2'd2);
        check("pre_bypass_empty", 66'(empty), 66'd1);

        push_valid = 2'b11;
        push_entry = {mk(32'h404), mk(32'h400)};
`ifdef IFQ_BYPASS_EN
        fetch_ack = 2'd1;
        #1;
        check("bypass_fe0", fe0, mk(32'h400));
        check("bypass_fe1", fe1, mk(32'h404));
        @(posedge clk);
        #1;
        push_valid = '0;
        fetch_ack = '0;
        check("bypass_count", 66'(count), 66'd1);
        check("bypass_stored", fe0, mk(32'h404));
`else
        fetch_ack = 2'd0;
        #1;
        check("nobypass_fe0_valid", 66'(fe0[E_W-1]), 66'd0);
        @(posedge clk);
        #1;
        push_valid = '0;
        check("nobypass_count", 66'(count), 66'd2);
        check("nobypass_fe0", fe0, mk(32'h400));
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
